// File: rtl/led_pkg.sv
// ==========================================================================
// led_pkg : shared LED one-wire protocol constants and decoder enums
// Revision: 1.0
// ==========================================================================
`default_nettype none

package led_pkg;

  // Nominal encoder timing in 100 MHz clk cycles.
  localparam int T0H   = 49;
  localparam int T0L   = 74;
  localparam int T1H   = 86;
  localparam int T1L   = 37;
  localparam int T_GAP = 5000;

  localparam logic [1:0] S_SYNC = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_LOW  = 2'd3;

  typedef enum logic [1:0] {
    ST_SYNC = S_SYNC,
    ST_IDLE = S_IDLE,
    ST_HIGH = S_HIGH,
    ST_LOW  = S_LOW
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_SHORT   = 2'd1,
    ERR_LONG    = 2'd2,
    ERR_PARTIAL = 2'd3
  } err_code_e;

endpackage

`default_nettype wire

// File: rtl/din_sync.sv
// ==========================================================================
// din_sync : 2-flop synchronizer for din with rise/fall detect
// Revision: 1.0
// ==========================================================================
`default_nettype none

module din_sync
  import led_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic din_s,
  output logic rise,
  output logic fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic dly_q, dly_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    dly_d   = sync2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dly_q   <= dly_d;
    end
  end

  assign din_s = sync2_q;
  assign rise  = sync2_q & ~dly_q;
  assign fall  = ~sync2_q & dly_q;

endmodule

`default_nettype wire

// File: rtl/led_stream_decoder.sv
// ==========================================================================
// led_stream_decoder : one-wire GRB LED stream to 24-bit words + framing
// Revision: 1.0
// ==========================================================================
`default_nettype none

module led_stream_decoder
  import led_pkg::*;
#(
  parameter int T_THRESH   = 68,
  parameter int T_MIN_HIGH = 20,
  parameter int T_MAX_HIGH = 120,
  parameter int T_RESET    = 4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  output logic [23:0] word_out,
  output logic        word_valid,
  output logic [7:0]  word_index,
  output logic        frame_done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        busy
);

  localparam logic [7:0]  THRESH_C = T_THRESH[7:0];
  localparam logic [7:0]  MIN_C    = T_MIN_HIGH[7:0];
  localparam logic [7:0]  MAX_C    = T_MAX_HIGH[7:0];
  localparam logic [11:0] RESET_C  = T_RESET[11:0];

  logic din_s, rise, fall;

  din_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .din_s (din_s),
    .rise  (rise),
    .fall  (fall)
  );

  state_e      state_q, state_d;
  logic [7:0]  high_cnt_q, high_cnt_d;
  logic [11:0] low_cnt_q, low_cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [23:0] word_out_q, word_out_d;
  logic        word_valid_q, word_valid_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  word_index_q, word_index_d;
  logic        frame_done_q, frame_done_d;
  logic        err_q, err_d;
  err_code_e   err_code_q, err_code_d;

  logic [7:0]  high_inc;
  logic [11:0] low_inc;
  logic [7:0]  idx_inc;
  logic [23:0] shifted;

  assign high_inc = (high_cnt_q == 8'hFF) ? high_cnt_q : high_cnt_q + 8'd1;
  assign low_inc  = (low_cnt_q == 12'hFFF) ? low_cnt_q : low_cnt_q + 12'd1;
  assign idx_inc  = (idx_q == 8'hFF) ? idx_q : idx_q + 8'd1;
  assign shifted  = {shift_q[22:0], (high_cnt_q >= THRESH_C)};

  always_comb begin
    state_d      = state_q;
    high_cnt_d   = high_cnt_q;
    low_cnt_d    = low_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    word_out_d   = word_out_q;
    word_valid_d = 1'b0;
    idx_d        = idx_q;
    word_index_d = word_index_q;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
    err_code_d   = err_code_q;

    case (state_q)
      ST_SYNC: begin
        // Wait for one full reset gap before trusting the line.
        if (din_s) begin
          low_cnt_d = 12'd0;
        end else if (low_inc >= RESET_C) begin
          state_d   = ST_IDLE;
          low_cnt_d = 12'd0;
        end else begin
          low_cnt_d = low_inc;
        end
      end
      ST_IDLE: begin
        if (rise) begin
          state_d    = ST_HIGH;
          high_cnt_d = 8'd1;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          state_d   = ST_LOW;
          low_cnt_d = 12'd1;  // the fall cycle is the first low cycle
          if (high_cnt_q < MIN_C) begin
            err_d      = 1'b1;
            err_code_d = ERR_SHORT;
          end else begin
            shift_d = shifted;
            if (bit_cnt_q == 5'd23) begin
              word_out_d   = shifted;
              word_valid_d = 1'b1;
              word_index_d = idx_q;
              idx_d        = idx_inc;
              bit_cnt_d    = 5'd0;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end else if (high_cnt_q >= MAX_C) begin
          // Another high cycle past the maximum: line is stuck or foreign.
          err_d        = 1'b1;
          err_code_d   = ERR_LONG;
          bit_cnt_d    = 5'd0;
          shift_d      = 24'd0;
          idx_d        = 8'd0;
          word_index_d = 8'd0;
          high_cnt_d   = 8'd0;
          low_cnt_d    = 12'd0;
          state_d      = ST_SYNC;
        end else begin
          high_cnt_d = high_inc;
        end
      end
      ST_LOW: begin
        if (rise) begin
          state_d    = ST_HIGH;
          high_cnt_d = 8'd1;
        end else if (low_inc >= RESET_C) begin
          frame_done_d = 1'b1;
          idx_d        = 8'd0;
          word_index_d = 8'd0;
          low_cnt_d    = 12'd0;
          state_d      = ST_IDLE;
          if (bit_cnt_q != 5'd0) begin
            err_d      = 1'b1;
            err_code_d = ERR_PARTIAL;
            bit_cnt_d  = 5'd0;
            shift_d    = 24'd0;
          end
        end else begin
          low_cnt_d = low_inc;
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_SYNC;
      high_cnt_q   <= 8'd0;
      low_cnt_q    <= 12'd0;
      bit_cnt_q    <= 5'd0;
      shift_q      <= 24'd0;
      word_out_q   <= 24'd0;
      word_valid_q <= 1'b0;
      idx_q        <= 8'd0;
      word_index_q <= 8'd0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      high_cnt_q   <= high_cnt_d;
      low_cnt_q    <= low_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
      idx_q        <= idx_d;
      word_index_q <= word_index_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
  assign word_index = word_index_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign busy       = (state_q == ST_HIGH) || (state_q == ST_LOW);

endmodule

`default_nettype wire
